// File: rtl/csrng_rsp_model_pkg.sv
// Shared types for the CSRNG responder model: FSM states, application command
// codes, the command header layout and the request/response channel structs.
package csrng_rsp_model_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADATA,
    ST_DELAY,
    ST_EXEC,
    ST_GEN,
    ST_ACK
  } state_e;

  localparam logic [3:0] ACMD_INS = 4'd1;
  localparam logic [3:0] ACMD_RES = 4'd2;
  localparam logic [3:0] ACMD_GEN = 4'd3;
  localparam logic [3:0] ACMD_UPD = 4'd4;
  localparam logic [3:0] ACMD_UNI = 4'd5;

  localparam logic [127:0] SEED_DEFAULT = 128'h8d0e0c5f_a5a88277_e7ee1e47_222218a5;

  // Header view of a request word; additional-data beats reuse the same 32 bits.
  typedef struct packed {
    logic [6:0]  rsvd;
    logic [12:0] glen;
    logic [3:0]  flag0;
    logic [3:0]  clen;
    logic [3:0]  acmd;
  } hdr_t;

  typedef struct packed {
    logic valid;
    hdr_t bits;
    logic genbits_ready;
  } csrng_req_t;

  typedef struct packed {
    logic         req_ready;
    logic         rsp_ack;
    logic         rsp_sts;
    logic         genbits_valid;
    logic         genbits_fips;
    logic [127:0] genbits_bus;
  } csrng_rsp_t;

endpackage

// File: rtl/csrng_rsp_model_chan.sv
// One CSRNG application channel: parses a command, tracks instantiate state,
// waits out the response delay, streams genbits and acks with a status.
module csrng_rsp_model_chan
  import csrng_rsp_model_pkg::*;
#(
  parameter int unsigned  ChanIdx     = 0,
  parameter int unsigned  RspDelay    = 4,
  parameter logic [127:0] Seed        = SEED_DEFAULT,
  parameter logic         FipsDefault = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       err_inj_i,
  input  csrng_req_t csrng_req_i,
  output csrng_rsp_t csrng_rsp_o,
  output logic       inst_o
);

  localparam int unsigned DelayLast = (RspDelay > 0) ? RspDelay - 1 : 0;
  localparam logic [95:0] ChanTag   = 96'(ChanIdx);

  state_e       state;
  logic [3:0]   acmd;
  logic [12:0]  glen_left;
  logic [3:0]   words_left;
  logic [1:0]   word_idx;
  logic [127:0] adata;
  logic [31:0]  delay_cnt;
  logic [127:0] key;
  logic [31:0]  blk_cnt;
  logic         inst;
  logic         err_pend;
  logic         sts;
  logic         cmd_err;
  logic         accept;

  assign accept = csrng_req_i.valid && csrng_rsp_o.req_ready;
  assign inst_o = inst;

  always_comb begin
    cmd_err = err_pend || err_inj_i;
    case (acmd)
      ACMD_INS: if (inst) cmd_err = 1'b1;
      ACMD_RES, ACMD_GEN, ACMD_UPD, ACMD_UNI: if (!inst) cmd_err = 1'b1;
      default: cmd_err = 1'b1;
    endcase
  end

  // Additional data is staged in adata and only folded into the key once the
  // command resolves without error, so a rejected command leaves the key intact.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      acmd       <= '0;
      glen_left  <= '0;
      words_left <= '0;
      word_idx   <= '0;
      adata      <= '0;
      delay_cnt  <= '0;
      key        <= Seed;
      blk_cnt    <= '0;
      inst       <= 1'b0;
      err_pend   <= 1'b0;
      sts        <= 1'b0;
    end else if (!enable_i) begin
      state      <= ST_IDLE;
      acmd       <= '0;
      glen_left  <= '0;
      words_left <= '0;
      word_idx   <= '0;
      adata      <= '0;
      delay_cnt  <= '0;
      key        <= Seed;
      blk_cnt    <= '0;
      inst       <= 1'b0;
      err_pend   <= 1'b0;
      sts        <= 1'b0;
    end else begin
      if (err_inj_i) err_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            acmd       <= csrng_req_i.bits.acmd;
            glen_left  <= csrng_req_i.bits.glen;
            words_left <= csrng_req_i.bits.clen;
            word_idx   <= '0;
            adata      <= '0;
            delay_cnt  <= '0;
            if (csrng_req_i.bits.clen != 4'd0) state <= ST_ADATA;
            else state <= (RspDelay > 0) ? ST_DELAY : ST_EXEC;
          end
        end
        ST_ADATA: begin
          if (accept) begin
            adata[{word_idx, 5'b0} +: 32] <= adata[{word_idx, 5'b0} +: 32] ^ csrng_req_i.bits;
            word_idx   <= word_idx + 2'd1;
            words_left <= words_left - 4'd1;
            if (words_left == 4'd1) state <= (RspDelay > 0) ? ST_DELAY : ST_EXEC;
          end
        end
        ST_DELAY: begin
          if (delay_cnt == 32'(DelayLast)) state <= ST_EXEC;
          else delay_cnt <= delay_cnt + 32'd1;
        end
        ST_EXEC: begin
          sts   <= cmd_err;
          state <= ST_ACK;
          if (!cmd_err) begin
            case (acmd)
              ACMD_INS, ACMD_RES: begin
                inst    <= 1'b1;
                blk_cnt <= '0;
                key     <= key ^ adata;
              end
              ACMD_UPD: key <= key ^ adata;
              ACMD_UNI: begin
                inst <= 1'b0;
                key  <= Seed;
              end
              ACMD_GEN: if (glen_left != 13'd0) state <= ST_GEN;
              default: ;
            endcase
          end
        end
        ST_GEN: begin
          if (csrng_req_i.genbits_ready) begin
            blk_cnt   <= blk_cnt + 32'd1;
            glen_left <= glen_left - 13'd1;
            if (glen_left == 13'd1) state <= ST_ACK;
          end
        end
        ST_ACK: begin
          // An injection arriving during the ack belongs to the next command.
          err_pend <= err_inj_i;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    csrng_rsp_o           = '0;
    csrng_rsp_o.req_ready = enable_i && (state == ST_IDLE || state == ST_ADATA);
    csrng_rsp_o.rsp_ack   = enable_i && (state == ST_ACK);
    csrng_rsp_o.rsp_sts   = enable_i && (state == ST_ACK) && sts;
    if (state == ST_GEN) begin
      csrng_rsp_o.genbits_valid = 1'b1;
      csrng_rsp_o.genbits_fips  = FipsDefault;
      csrng_rsp_o.genbits_bus   = key ^ {ChanTag, blk_cnt};
    end
  end

endmodule

// File: rtl/csrng_rsp_model.sv
// CSRNG responder model: NumApps independent application channels sitting on
// the csrng side of edn, each with its own key, counters and FSM.
module csrng_rsp_model
  import csrng_rsp_model_pkg::*;
#(
  parameter int unsigned  NumApps     = 2,
  parameter int unsigned  RspDelay    = 4,
  parameter logic [127:0] Seed        = SEED_DEFAULT,
  parameter logic         FipsDefault = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic       [NumApps-1:0] err_inj_i,
  input  csrng_req_t [NumApps-1:0] csrng_req_i,
  output csrng_rsp_t [NumApps-1:0] csrng_rsp_o,
  output logic       [NumApps-1:0] inst_o
);

  for (genvar i = 0; i < NumApps; i++) begin : g_chan
    csrng_rsp_model_chan #(
      .ChanIdx    (i),
      .RspDelay   (RspDelay),
      .Seed       (Seed),
      .FipsDefault(FipsDefault)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .enable_i   (enable_i),
      .err_inj_i  (err_inj_i[i]),
      .csrng_req_i(csrng_req_i[i]),
      .csrng_rsp_o(csrng_rsp_o[i]),
      .inst_o     (inst_o[i])
    );
  end

endmodule

// File: tb/tb_csrng_rsp_model.sv
// Directed bench for csrng_rsp_model: hand-computed genbits, ack latency,
// stall, error injection and enable-abort scenarios on a two-channel build.
module tb_csrng_rsp_model;
  import csrng_rsp_model_pkg::*;

  localparam logic [127:0] S = 128'h8d0e0c5f_a5a88277_e7ee1e47_222218a5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic       [1:0] err_inj;
  csrng_req_t [1:0] req;
  csrng_rsp_t [1:0] rsp;
  logic       [1:0] inst;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  csrng_rsp_model #(
    .NumApps    (2),
    .RspDelay   (4),
    .Seed       (S),
    .FipsDefault(1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .enable_i   (enable),
    .err_inj_i  (err_inj),
    .csrng_req_i(req),
    .csrng_rsp_o(rsp),
    .inst_o     (inst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [132:0] observed, input logic [132:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents a header (plus up to two data words) on consecutive cycles; t0 is the header cycle.
  task automatic send_cmd(input int ch, input logic [31:0] hdr, input logic [31:0] w0,
                          input logic [31:0] w1, input int nwords, output int t0);
    @(negedge clk);
    check($sformatf("ready_ch%0d", ch), 133'(rsp[ch].req_ready), 133'(1'b1));
    req[ch].valid = 1'b1;
    req[ch].bits  = hdr;
    t0 = cyc;
    if (nwords > 0) begin
      @(negedge clk);
      req[ch].bits = w0;
    end
    if (nwords > 1) begin
      @(negedge clk);
      req[ch].bits = w1;
    end
    @(negedge clk);
    req[ch].valid = 1'b0;
    req[ch].bits  = '0;
  endtask

  task automatic wait_ack(input int ch, input int t0, input int budget,
                          output int lat, output logic sts, output logic saw_valid);
    lat = -1;
    sts = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rsp[ch].genbits_valid) saw_valid = 1'b1;
      if (rsp[ch].rsp_ack) begin
        lat = cyc - t0;
        sts = rsp[ch].rsp_sts;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int ch, input int t0, input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (rsp[ch].genbits_valid) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int   t0;
    int   lat;
    logic sts;
    logic saw_valid;
    logic saw_ack;

    rst_n   = 1'b0;
    enable  = 1'b0;
    err_inj = '0;
    req     = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_rsp0", 133'(rsp[0]), 133'(0));
    check("reset_rsp1", 133'(rsp[1]), 133'(0));
    check("reset_inst", 133'(inst), 133'(0));
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("ready_after_enable", 133'({rsp[1].req_ready, rsp[0].req_ready}), 133'(2'b11));

    // Ch0 instantiate, clen=0
    send_cmd(0, 32'h0000_0001, '0, '0, 0, t0);
    wait_ack(0, t0, 20, lat, sts, saw_valid);
    check("ins_latency", 133'(lat), 133'(6));
    check("ins_sts", 133'(sts), 133'(0));
    @(negedge clk);
    check("ins_ack_one_cycle", 133'(rsp[0].rsp_ack), 133'(0));
    check("ins_inst", 133'(inst), 133'(2'b01));

    // Ch0 generate 4 blocks with ready held high
    req[0].genbits_ready = 1'b1;
    send_cmd(0, 32'h0000_4003, '0, '0, 0, t0);
    wait_valid(0, t0, 20, lat);
    check("gen4_first_valid_latency", 133'(lat), 133'(6));
    check("gen4_fips", 133'(rsp[0].genbits_fips), 133'(1));
    check("gen4_blk0", 133'(rsp[0].genbits_bus), 133'(128'h8d0e0c5f_a5a88277_e7ee1e47_222218a5));
    @(negedge clk);
    check("gen4_blk1", 133'(rsp[0].genbits_bus), 133'(128'h8d0e0c5f_a5a88277_e7ee1e47_222218a4));
    @(negedge clk);
    check("gen4_blk2", 133'(rsp[0].genbits_bus), 133'(128'h8d0e0c5f_a5a88277_e7ee1e47_222218a7));
    @(negedge clk);
    check("gen4_blk3", 133'(rsp[0].genbits_bus), 133'(128'h8d0e0c5f_a5a88277_e7ee1e47_222218a6));
    @(negedge clk);
    check("gen4_ack", 133'({rsp[0].rsp_ack, rsp[0].rsp_sts, rsp[0].genbits_valid}), 133'(3'b100));

    // Ch0 generate 2 blocks with a 3-cycle consumer stall
    req[0].genbits_ready = 1'b0;
    send_cmd(0, 32'h0000_2003, '0, '0, 0, t0);
    wait_valid(0, t0, 20, lat);
    check("gen2_first_valid_latency", 133'(lat), 133'(6));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("gen2_stall%0d", i), 133'(rsp[0].genbits_bus),
            133'(128'h8d0e0c5f_a5a88277_e7ee1e47_222218a1));
      if (i < 3) @(negedge clk);
    end
    req[0].genbits_ready = 1'b1;
    @(negedge clk);
    check("gen2_blk5", 133'(rsp[0].genbits_bus), 133'(128'h8d0e0c5f_a5a88277_e7ee1e47_222218a0));
    @(negedge clk);
    check("gen2_ack", 133'({rsp[0].rsp_ack, rsp[0].rsp_sts}), 133'(2'b10));

    // Uninstantiate, then generate must fail without producing genbits
    send_cmd(0, 32'h0000_0005, '0, '0, 0, t0);
    wait_ack(0, t0, 20, lat, sts, saw_valid);
    check("uni_sts", 133'(sts), 133'(0));
    @(negedge clk);
    check("uni_inst", 133'(inst), 133'(2'b00));
    send_cmd(0, 32'h0000_1003, '0, '0, 0, t0);
    wait_ack(0, t0, 20, lat, sts, saw_valid);
    check("gen_uninst_latency", 133'(lat), 133'(6));
    check("gen_uninst_sts", 133'(sts), 133'(1));
    check("gen_uninst_no_valid", 133'(saw_valid), 133'(0));

    // Instantiate with two words of additional data, then one block
    @(negedge clk);
    send_cmd(0, 32'h0000_0021, 32'hFFFF_FFFF, 32'h0000_0001, 2, t0);
    wait_ack(0, t0, 20, lat, sts, saw_valid);
    check("ins_clen2_latency", 133'(lat), 133'(8));
    check("ins_clen2_sts", 133'(sts), 133'(0));
    send_cmd(0, 32'h0000_1003, '0, '0, 0, t0);
    wait_valid(0, t0, 20, lat);
    check("gen_adata_blk0", 133'(rsp[0].genbits_bus), 133'(128'h8d0e0c5f_a5a88277_e7ee1e46_dddde75a));
    @(negedge clk);
    check("gen_adata_ack", 133'({rsp[0].rsp_ack, rsp[0].rsp_sts}), 133'(2'b10));

    // Ch1 error injection: first instantiate fails, second succeeds
    @(negedge clk);
    err_inj[1] = 1'b1;
    @(negedge clk);
    err_inj[1] = 1'b0;
    send_cmd(1, 32'h0000_0001, '0, '0, 0, t0);
    wait_ack(1, t0, 20, lat, sts, saw_valid);
    check("ch1_errinj_sts", 133'(sts), 133'(1));
    @(negedge clk);
    check("ch1_errinj_inst", 133'(inst), 133'(2'b01));
    send_cmd(1, 32'h0000_0001, '0, '0, 0, t0);
    wait_ack(1, t0, 20, lat, sts, saw_valid);
    check("ch1_ins_sts", 133'(sts), 133'(0));
    @(negedge clk);
    check("ch1_ins_inst", 133'(inst), 133'(2'b11));

    // Both channels generate together; enable drops mid-stream
    req[1].genbits_ready = 1'b1;
    @(negedge clk);
    req[0].valid = 1'b1;
    req[0].bits  = 32'h0000_4003;
    req[1].valid = 1'b1;
    req[1].bits  = 32'h0000_4003;
    t0 = cyc;
    @(negedge clk);
    req = '0;
    req[0].genbits_ready = 1'b1;
    req[1].genbits_ready = 1'b1;
    wait_valid(1, t0, 20, lat);
    check("par_ch1_latency", 133'(lat), 133'(6));
    check("par_ch0_valid", 133'(rsp[0].genbits_valid), 133'(1));
    check("par_ch0_blk1", 133'(rsp[0].genbits_bus), 133'(128'h8d0e0c5f_a5a88277_e7ee1e46_dddde75b));
    check("par_ch1_blk0", 133'(rsp[1].genbits_bus), 133'(128'h8d0e0c5f_a5a88277_e7ee1e46_222218a5));
    @(negedge clk);
    check("par_ch1_blk1", 133'(rsp[1].genbits_bus), 133'(128'h8d0e0c5f_a5a88277_e7ee1e46_222218a4));
    enable = 1'b0;
    @(negedge clk);
    check("abort_rsp0", 133'(rsp[0]), 133'(0));
    check("abort_rsp1", 133'(rsp[1]), 133'(0));
    check("abort_inst", 133'(inst), 133'(0));
    saw_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp[0].rsp_ack || rsp[1].rsp_ack) saw_ack = 1'b1;
      @(negedge clk);
    end
    check("abort_no_ack", 133'(saw_ack), 133'(0));

    // After re-enable the channel is uninstantiated again
    enable = 1'b1;
    send_cmd(0, 32'h0000_1003, '0, '0, 0, t0);
    wait_ack(0, t0, 20, lat, sts, saw_valid);
    check("reenable_gen_sts", 133'(sts), 133'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
